// File: rtl/sram_access_seq.sv
// sram_access_seq: single-port access sequencer for the mixed-signal SRAM macro.
// Sequences precharge, wordline, write-drive or sense strobes and returns a
// one-cycle response pulse carrying the read word and an error flag.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   req_valid/req_ready    request handshake; accepted only in IDLE
//   req_we, req_addr,      request kind (1=write), row address, write data
//   req_wdata
//   rsp_valid, rsp_rdata,  one-cycle completion pulse, read data (held),
//   rsp_err                error (out-of-range row or unstable sense)
//   pre_en, wl, wr_en,     array strobes: precharge, one-hot wordline,
//   wr_data, sae           write driver enable/data, sense amp enable
//   sa_preout              real-valued sense amp column outputs (0.0/1.5 V)
//
// Optional feature macro: SA_DOUBLE_SAMPLE_EN
//   defined   -> reads sense twice; a disagreement raises rsp_err
//   undefined -> single sense cycle; rsp_err flags out-of-range rows only

module sram_access_seq #(
    parameter int COLS     = 16,
    parameter int ROWS     = 16,
    parameter int ROW_BITS = 4,
    parameter int T_PRE    = 2,
    parameter int T_WL     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ROW_BITS-1:0] req_addr,
    input  logic [COLS-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [COLS-1:0]     rsp_rdata,
    output logic                rsp_err,
    output logic                pre_en,
    output logic [ROWS-1:0]     wl,
    output logic                wr_en,
    output logic [COLS-1:0]     wr_data,
    output logic                sae,
    input  real                 sa_preout [0:COLS-1]
);

    localparam int TMAX = (T_PRE > T_WL) ? T_PRE : T_WL;
    localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] PRE_LAST = CW'(T_PRE - 1);
    localparam logic [CW-1:0] WL_LAST  = CW'(T_WL - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WL,
        SENSE1,
        SENSE2,
        RESP
    } state_t;

`ifdef SA_DOUBLE_SAMPLE_EN
    localparam state_t SENSE_LAST = SENSE2;
`else
    localparam state_t SENSE_LAST = SENSE1;
`endif

    state_t              state;
    state_t              nxt;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    logic                ready_q;
    logic [ROW_BITS-1:0] addr_q;
    logic                we_q;
    logic [COLS-1:0]     wdata_q;
    logic [COLS-1:0]     rdata_q;
    logic                accept;
    logic                in_range;
    logic [ROWS-1:0]     row_hot;
    logic [COLS-1:0]     sa_bits;
    logic [COLS-1:0]     sense_word;
    logic                mism;

    assign accept   = (state == IDLE) && ready_q && req_valid;
    assign in_range = ({1'b0, addr_q} < (ROW_BITS + 1)'(ROWS));
    assign row_hot  = ROWS'(1) << addr_q;

    // Slice each analog column at mid-rail.
    always_comb begin
        sa_bits = '0;
        for (int i = 0; i < COLS; i++) begin
            sa_bits[i] = (sa_preout[i] > 0.75);
        end
    end

    // An unselected row yields garbage on the columns; force it to zero.
    assign sense_word = in_range ? sa_bits : '0;

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (accept) nxt = PRE;
            end
            PRE: begin
                if (cnt == PRE_LAST) begin
                    nxt     = WL;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WL: begin
                if (cnt == WL_LAST) begin
                    nxt     = we_q ? RESP : SENSE1;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
`ifdef SA_DOUBLE_SAMPLE_EN
            SENSE1:  nxt = SENSE2;
            SENSE2:  nxt = RESP;
`else
            SENSE1:  nxt = RESP;
`endif
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Strobes decode straight from the state register so an async reset
    // drops them all in the same instant.
    always_comb begin
        pre_en    = (state == PRE);
        sae       = (state == SENSE1) || (state == SENSE2);
        wl        = '0;
        if ((state == WL || sae) && in_range) wl = row_hot;
        wr_en     = (state == WL) && we_q && in_range;
        wr_data   = wr_en ? wdata_q : '0;
        rsp_valid = (state == RESP);
        rsp_err   = rsp_valid && (!in_range || mism);
    end

    assign req_ready = ready_q;
    assign rsp_rdata = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state   <= nxt;
            cnt     <= cnt_nxt;
            // Ready is registered so it first rises one edge after reset
            // release and one cycle after the response pulse.
            ready_q <= (nxt == IDLE);
            if (accept) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
            end
            if (state == SENSE_LAST) rdata_q <= sense_word;
        end
    end

`ifdef SA_DOUBLE_SAMPLE_EN
    logic [COLS-1:0] samp1_q;
    logic            mism_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp1_q <= '0;
            mism_q  <= 1'b0;
        end else begin
            if (accept) mism_q <= 1'b0;
            if (state == SENSE1) samp1_q <= sense_word;
            if (state == SENSE2) mism_q <= (samp1_q != sense_word);
        end
    end

    assign mism = mism_q;
`else
    assign mism = 1'b0;
`endif

endmodule

// File: doc/sram_access_seq.md
Name: sram_access_seq

Overview:
Single-port access sequencer for the mixed-signal SRAM macro. Accepts one read or write request at a time and drives the array control strobes in a fixed timed order: precharge, wordline, write drive or sense enable. It digitizes the per-column real-valued sense amplifier outputs and returns read data through a one-cycle response pulse. It sits between the digital host interface and the analog array/sense-amp columns.

Parameters:
COLS, 16, data width / number of bitline columns
ROWS, 16, number of wordlines
ROW_BITS, 4, address width; ROWS <= 2**ROW_BITS
T_PRE, 2, precharge cycles (>=1)
T_WL, 3, wordline-active cycles before sense/write end (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_we  in  1  1=write, 0=read
req_addr  in  ROW_BITS  row address
req_wdata  in  COLS  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  COLS  read data, held until the next read completes
rsp_err  out  1  access error, qualified by rsp_valid
pre_en  out  1  bitline precharge enable
wl  out  ROWS  one-hot wordline select
wr_en  out  1  write driver enable
wr_data  out  COLS  write driver data
sae  out  1  sense amp enable
sa_preout  in  real[0:COLS-1]  sense amp outputs, 0.0 or 1.5 V

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, pre_en=0, wl=0, wr_en=0, wr_data=0, sae=0. State=IDLE. Counters=0.
- Reset is asynchronous. Asserting it mid-access aborts the access at once. All strobes drop in the same instant and no response is issued.
- req_ready=1 only in IDLE. A request is accepted when req_valid&&req_ready at a clock edge. The controller latches addr, we and wdata, then moves to PRE.
- PRE: pre_en=1 for exactly T_PRE cycles. wl=0, sae=0.
- WL: pre_en=0, wl=one-hot(addr) for T_WL cycles. On a write, wr_en=1 and wr_data=latched wdata for all T_WL cycles. pre_en and wl are never both high.
- SENSE (read only, 1 cycle): wl is held and sae=1. At the end of this cycle, bit i of the captured word = (sa_preout[i] > 0.75). Next state is RESP.
- A write goes WL->RESP directly. wr_en and wr_data drop to 0 on entering RESP.
- RESP (1 cycle): all strobes=0, rsp_valid=1. On a read, rsp_rdata=captured word. On a write, rsp_rdata is unchanged. Next state is IDLE.
- Latency, accept edge to rsp_valid: read = T_PRE+T_WL+2 cycles; write = T_PRE+T_WL+1 cycles. Defaults give 7 for a read and 6 for a write.
- Back-to-back: IDLE lasts at least 1 cycle between accesses, so req_ready rises the cycle after rsp_valid.
- Out-of-range address (addr >= ROWS): the full timing sequence still runs, but wl stays 0 throughout and wr_en stays 0. The read word is forced to 0 and rsp_err=1 with rsp_valid.
- The response has no backpressure. rsp_valid is a single-cycle pulse.
- req_* inputs are ignored outside the accept edge.

Optional Feature:
SA_DOUBLE_SAMPLE_EN. When defined, a read has SENSE1 and SENSE2, each 1 cycle, with sae and wl held across both. Columns are sampled at the end of each. rsp_rdata = the second sample. rsp_err = (sample1 != sample2) OR out-of-range. Read latency becomes T_PRE+T_WL+3. When undefined, there is a single SENSE cycle, and rsp_err reflects only out-of-range.

Test Plan:
- Reset: hold rst_n=0 -> all outputs 0. Release -> req_ready=1 on the next edge.
- Write addr=5, wdata=16'hA5C3 (defaults) -> pre_en high 2 cycles, then wl=16'h0020 with wr_en=1 and wr_data=A5C3 for 3 cycles, then rsp_valid at cycle 6 with rsp_err=0.
- Read addr=5, model drives sa_preout = 1.5 V on bits set in A5C3 and 0.0 V elsewhere -> sae exactly 1 cycle after 3 wl cycles, rsp_valid at cycle 7, rsp_rdata=16'hA5C3.
- Read addr=20 with ROW_BITS=5, ROWS=16 -> wl stays 0, rsp_rdata=0, rsp_err=1. Check pre_en/wl mutual exclusion on every cycle.
- Back-to-back: req_valid held high for two reads -> second accept exactly 1 cycle after the first rsp_valid. req_ready=0 throughout the busy period.
- Abort: rst_n pulsed low during WL of a write -> wl and wr_en fall immediately, no rsp_valid. With SA_DOUBLE_SAMPLE_EN, toggle bit 0 of sa_preout between SENSE1 and SENSE2 -> rsp_err=1 and latency 8.
